orb_pack_reader: RTL

Read-side counterpart of the orbital packet writer. Fetches one 32-word packet per request from the shared 2048x12 orbital buffer (1-cycle-latency synchronous RAM read port) and presents it word by word on a valid/ready stream to the frame transmitter. It tracks the packet pointer the same way the writer does: 64 packets of 32 words, even address = channel 1, odd address = channel 2, restart on SW toggle. It also checks the word format {0, data[7:0], 000}.

---
 rtl/orb_pack_reader.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/orb_pack_reader.sv
// orb_pack_reader: fetches one packet per request from the orbital buffer
// (1-cycle-latency synchronous RAM) and streams it word by word over a
// valid/ready handshake. Tracks the packet pointer like the writer does
// and flags words that break the {0, data[7:0], 000} format.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   req             packet request pulse
//   SW              asynchronous restart toggle (synchronised internally)
//   rdData          RAM read data, valid the cycle after RdEn
//   RdEn, RdAddr    registered RAM read port controls
//   oWord, oByte    presented word and its data byte oWord[10:3]
//   oChan           0 = channel 1 (even word), 1 = channel 2 (odd word)
//   oValid, iReady  output stream handshake
//   busy            packet in progress
//   packDone        pulse after the last word of a packet is accepted
//   ovrErr          pulse when req arrives while busy
//   fmtErr          pulse when a captured word is malformed
module orb_pack_reader #(
  parameter int unsigned ADDR_W     = 11,
  parameter int unsigned PACK_WORDS = 32,
  parameter int unsigned PACKS      = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              SW,
  input  logic [11:0]       rdData,
  output logic              RdEn,
  output logic [ADDR_W-1:0] RdAddr,
  output logic [11:0]       oWord,
  output logic [7:0]        oByte,
  output logic              oChan,
  output logic              oValid,
  input  logic              iReady,
  output logic              busy,
  output logic              packDone,
  output logic              ovrErr,
  output logic              fmtErr
);

  localparam int unsigned IDX_W = $clog2(PACK_WORDS);
  localparam int unsigned PTR_W = $clog2(PACKS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    CAPTURE = 2'd2,
    PRESENT = 2'd3
  } state_t;

  state_t           state;
  logic [PTR_W-1:0] cntPack;
  logic [IDX_W-1:0] idx;

  // SW synchroniser, previous-value register and post-reset arm flag
  logic swMeta;
  logic swSync;
  logic swOld;
  logic armed;
  logic swChg;

  // swOld only becomes meaningful once it has loaded swSync after reset
  assign swChg = armed && (swSync != swOld);

  // oByte is a slice of the registered word, so it is registered too
  assign oByte = oWord[10:3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      swMeta <= 1'b0;
      swSync <= 1'b0;
      swOld  <= 1'b0;
      armed  <= 1'b0;
    end else begin
      swMeta <= SW;
      swSync <= swMeta;
      swOld  <= swSync;
      armed  <= 1'b1;
    end
  end

  // Packet fetch / present FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cntPack  <= '0;
      idx      <= '0;
      RdEn     <= 1'b0;
      RdAddr   <= '0;
      oWord    <= '0;
      oChan    <= 1'b0;
      oValid   <= 1'b0;
      busy     <= 1'b0;
      packDone <= 1'b0;
      ovrErr   <= 1'b0;
      fmtErr   <= 1'b0;
    end else begin
      packDone <= 1'b0;
      ovrErr   <= 1'b0;
      fmtErr   <= 1'b0;

      if (swChg) begin
        // Restart wins over req and handshake; a coincident req is dropped
        state   <= IDLE;
        cntPack <= '0;
        idx     <= '0;
        RdEn    <= 1'b0;
        oValid  <= 1'b0;
        busy    <= 1'b0;
      end else begin
        if (req && (state != IDLE)) begin
          ovrErr <= 1'b1;
        end

        case (state)
          IDLE: begin
            if (req) begin
              RdAddr <= ADDR_W'({cntPack, IDX_W'(0)});
              RdEn   <= 1'b1;
              idx    <= '0;
              busy   <= 1'b1;
              state  <= WAIT;
            end
          end

          WAIT: begin
            RdEn  <= 1'b0;
            state <= CAPTURE;
          end

          CAPTURE: begin
            oWord  <= rdData;
            oChan  <= idx[0];
            oValid <= 1'b1;
            fmtErr <= rdData[11] | (|rdData[2:0]);
            state  <= PRESENT;
          end

          PRESENT: begin
            if (iReady) begin
              oValid <= 1'b0;
              if (idx == IDX_W'(PACK_WORDS - 1)) begin
                cntPack  <= cntPack + PTR_W'(1);
                packDone <= 1'b1;
                busy     <= 1'b0;
                state    <= IDLE;
              end else begin
                idx    <= idx + IDX_W'(1);
                RdAddr <= ADDR_W'({cntPack, idx + IDX_W'(1)});
                RdEn   <= 1'b1;
                state  <= WAIT;
              end
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
